timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 128 ++++++++++++
 tb/tb_timer_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one shared hardware timer to four requesters.
// It programs the timer over a simple write bus and reports expiry or cancellation.
module timer_arbiter (
   input  logic         clk,
   input  logic         reset,
   input  logic [3:0]   req,
   input  logic [127:0] period,
   input  logic [3:0]   cancel,
   output logic [3:0]   grant,
   output logic [3:0]   done,
   output logic         expired,
   output logic [31:0]  tmr_address,
   output logic [31:0]  tmr_data,
   output logic         tmr_wr,
   output logic         tmr_rd,
   input  logic         tmr_timeout
);

   localparam logic [31:0] ADDR_TIMEOUT = 32'h8000_0003;
   localparam logic [31:0] ADDR_START   = 32'h8000_0001;
   localparam logic [31:0] ADDR_STOP    = 32'h8000_0002;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_CLRSTOP = 3'd2;
   localparam logic [2:0] S_START   = 3'd3;
   localparam logic [2:0] S_ARM     = 3'd4;
   localparam logic [2:0] S_WAIT    = 3'd5;
   localparam logic [2:0] S_STOP    = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   logic [2:0]  state;
   logic [1:0]  last;
   logic [31:0] per_q;
   logic [1:0]  win;
   logic [1:0]  idx;
   logic        win_vld;
   logic [31:0] win_per;
   logic [1:0]  owner;
   logic        owner_cancel;

   // Scan from the lowest priority (last) upward so the nearest requester after last wins.
   always_comb begin
      win     = last;
      win_vld = 1'b0;
      idx     = '0;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (req[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

   assign win_per = period[{win, 5'd0} +: 32];

   always_comb begin
      owner = 2'd0;
      for (int i = 0; i < 4; i++)
         if (grant[i]) owner = 2'(i);
   end

   assign owner_cancel = |(cancel & grant);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         grant   <= '0;
         per_q   <= '0;
         last    <= 2'd3;
         expired <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               expired <= 1'b0;
               if (win_vld) begin
                  grant <= 4'b0001 << win;
                  per_q <= win_per;
                  state <= (win_per == 32'd0) ? S_DONE : S_LOAD;
               end
            end
            S_LOAD:    state <= S_CLRSTOP;
            S_CLRSTOP: state <= S_START;
            S_START:   state <= S_ARM;
            S_ARM:     state <= S_WAIT;
            S_WAIT: begin
               // Timeout takes precedence over a simultaneous cancel.
               if (tmr_timeout) begin
                  state   <= S_DONE;
                  expired <= 1'b1;
               end else if (owner_cancel) begin
                  state <= S_STOP;
               end
            end
            S_STOP: begin
               state   <= S_DONE;
               expired <= 1'b0;
            end
            S_DONE: begin
               state   <= S_IDLE;
               grant   <= '0;
               last    <= owner;
               expired <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      tmr_wr      = 1'b0;
      tmr_address = '0;
      tmr_data    = '0;
      case (state)
         S_LOAD:    begin tmr_wr = 1'b1; tmr_address = ADDR_TIMEOUT; tmr_data = per_q; end
         S_CLRSTOP: begin tmr_wr = 1'b1; tmr_address = ADDR_STOP;    tmr_data = 32'd0; end
         S_START:   begin tmr_wr = 1'b1; tmr_address = ADDR_START;   tmr_data = 32'd1; end
         S_ARM:     begin tmr_wr = 1'b1; tmr_address = ADDR_START;   tmr_data = 32'd0; end
         S_STOP:    begin tmr_wr = 1'b1; tmr_address = ADDR_STOP;    tmr_data = 32'd1; end
         default:   ;
      endcase
   end

   assign done   = (state == S_DONE) ? grant : 4'b0000;
   assign tmr_rd = 1'b0;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed vector table, hand sequences for reset and
// round-robin, and randomized transactions checked against a transaction-level model.
module tb_timer_arbiter;

   localparam logic [31:0] A_TV    = 32'h8000_0003;
   localparam logic [31:0] A_START = 32'h8000_0001;
   localparam logic [31:0] A_STOP  = 32'h8000_0002;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req;
   logic [127:0] period;
   logic [3:0]   cancel;
   logic [3:0]   grant;
   logic [3:0]   done;
   logic         expired;
   logic [31:0]  tmr_address;
   logic [31:0]  tmr_data;
   logic         tmr_wr;
   logic         tmr_rd;
   logic         tmr_timeout;

   int n_cmp = 0;
   int n_bad = 0;
   int last_m = 3;

   timer_arbiter dut (
      .clk(clk), .reset(reset), .req(req), .period(period), .cancel(cancel),
      .grant(grant), .done(done), .expired(expired), .tmr_address(tmr_address),
      .tmr_data(tmr_data), .tmr_wr(tmr_wr), .tmr_rd(tmr_rd), .tmr_timeout(tmr_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   req;
      logic [3:0]   cancel;
      logic         timeout;
      logic [3:0]   grant;
      logic         wr;
      logic [31:0]  addr;
      logic [31:0]  data;
      logic [3:0]   done;
      logic         expired;
   } vec_t;

   function automatic vec_t mk(logic [3:0] r, logic [3:0] c, logic t, logic [3:0] g,
                               logic w, logic [31:0] a, logic [31:0] d, logic [3:0] dn, logic e);
      vec_t v;
      v.req = r; v.cancel = c; v.timeout = t; v.grant = g; v.wr = w;
      v.addr = a; v.data = d; v.done = dn; v.expired = e;
      return v;
   endfunction

   // Round-robin rule: first requester after the last granted one, wrapping.
   function automatic int rr(int last, logic [3:0] r);
      for (int k = 1; k <= 4; k++)
         if (r[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction

   task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk(string nm, logic [3:0] eg, logic ew, logic [31:0] ea, logic [31:0] ed,
                      logic [3:0] edn, logic eex);
      cmp({nm, " grant"}, 32'(grant), 32'(eg));
      cmp({nm, " tmr_wr"}, 32'(tmr_wr), 32'(ew));
      cmp({nm, " tmr_address"}, tmr_address, ea);
      cmp({nm, " tmr_data"}, tmr_data, ed);
      cmp({nm, " done"}, 32'(done), 32'(edn));
      cmp({nm, " expired"}, 32'(expired), 32'(eex));
      cmp({nm, " tmr_rd"}, 32'(tmr_rd), 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction from IDLE. mode: 0 timeout, 1 cancel, 2 both, -1 random.
   task automatic rand_op(input logic [3:0] freq, input int mode, output logic [3:0] obs);
      logic [3:0]   r;
      logic [127:0] per;
      logic [31:0]  p;
      logic [3:0]   g;
      logic [31:0]  wa[4];
      logic [31:0]  wd[4];
      int           w, m, n;
      r = (freq != 4'd0) ? freq : 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++)
         per[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
      w = rr(last_m, r);
      m = (mode >= 0) ? mode : int'($urandom_range(0, 2));
      if (mode >= 0 && per[32*w +: 32] == 32'd0) per[32*w +: 32] = 32'd3;
      p = per[32*w +: 32];
      g = 4'(1 << w);
      req = r; period = per; cancel = 4'($urandom) & ~g; tmr_timeout = 1'b0;
      tick();
      obs = grant;
      if (p == 32'd0) begin
         chk("zero period done", g, 1'b0, 32'd0, 32'd0, g, 1'b0);
      end else begin
         wa = '{A_TV, A_STOP, A_START, A_START};
         wd = '{p, 32'd0, 32'd1, 32'd0};
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("write %0d", k), g, 1'b1, wa[k], wd[k], 4'd0, 1'b0);
            req = 4'($urandom);
            period = {$urandom, $urandom, $urandom, $urandom};
            cancel = 4'($urandom);
            tick();
         end
         chk("wait", g, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
         n = $urandom_range(0, 3);
         repeat (n) begin
            cancel = 4'($urandom) & ~g;
            tick();
            chk("wait hold", g, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
         end
         cancel = ((m != 0) ? g : 4'd0) | (4'($urandom) & ~g);
         tmr_timeout = (m != 1);
         tick();
         tmr_timeout = 1'b0;
         cancel = 4'd0;
         if (m == 1) begin
            chk("stop write", g, 1'b1, A_STOP, 32'd1, 4'd0, 1'b0);
            tick();
            chk("done cancel", g, 1'b0, 32'd0, 32'd0, g, 1'b0);
         end else begin
            chk("done timeout", g, 1'b0, 32'd0, 32'd0, g, 1'b1);
         end
      end
      last_m = w;
      req = 4'd0;
      tick();
      chk("idle after", 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
   endtask

   vec_t        tbl[$];
   logic [3:0]  obs;

   initial begin
      reset = 1'b0; req = 4'd0; cancel = 4'd0; tmr_timeout = 1'b0;
      period = {32'd9, 32'd7, 32'd0, 32'd5};
      #3;
      chk("reset state", 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      tbl.push_back(mk(4'h1, 4'h0, 0, 4'h1, 1, A_TV,    32'd5, 4'h0, 0));
      tbl.push_back(mk(4'h0, 4'h1, 0, 4'h1, 1, A_STOP,  32'd0, 4'h0, 0));
      tbl.push_back(mk(4'h0, 4'h1, 0, 4'h1, 1, A_START, 32'd1, 4'h0, 0));
      tbl.push_back(mk(4'h0, 4'h1, 0, 4'h1, 1, A_START, 32'd0, 4'h0, 0));
      tbl.push_back(mk(4'h0, 4'h1, 0, 4'h1, 0, 32'd0,   32'd0, 4'h0, 0));
      tbl.push_back(mk(4'h0, 4'hE, 0, 4'h1, 0, 32'd0,   32'd0, 4'h0, 0));
      tbl.push_back(mk(4'h0, 4'h0, 1, 4'h1, 0, 32'd0,   32'd0, 4'h1, 1));
      tbl.push_back(mk(4'h2, 4'h0, 0, 4'h0, 0, 32'd0,   32'd0, 4'h0, 0));
      tbl.push_back(mk(4'h2, 4'h0, 0, 4'h2, 0, 32'd0,   32'd0, 4'h2, 0));
      tbl.push_back(mk(4'h0, 4'h0, 0, 4'h0, 0, 32'd0,   32'd0, 4'h0, 0));
      tbl.push_back(mk(4'h3, 4'h0, 0, 4'h1, 1, A_TV,    32'd5, 4'h0, 0));
      tbl.push_back(mk(4'h3, 4'h0, 0, 4'h1, 1, A_STOP,  32'd0, 4'h0, 0));
      tbl.push_back(mk(4'h3, 4'h0, 0, 4'h1, 1, A_START, 32'd1, 4'h0, 0));
      tbl.push_back(mk(4'h3, 4'h0, 0, 4'h1, 1, A_START, 32'd0, 4'h0, 0));
      tbl.push_back(mk(4'h3, 4'h0, 0, 4'h1, 0, 32'd0,   32'd0, 4'h0, 0));
      tbl.push_back(mk(4'h3, 4'h0, 1, 4'h1, 0, 32'd0,   32'd0, 4'h1, 1));
      tbl.push_back(mk(4'h0, 4'h0, 0, 4'h0, 0, 32'd0,   32'd0, 4'h0, 0));
      for (int i = 0; i < tbl.size(); i++) begin
         req = tbl[i].req; cancel = tbl[i].cancel; tmr_timeout = tbl[i].timeout;
         tick();
         chk($sformatf("vec %0d", i), tbl[i].grant, tbl[i].wr, tbl[i].addr, tbl[i].data,
             tbl[i].done, tbl[i].expired);
      end
      tmr_timeout = 1'b0;
      last_m = 0;

      // Owner 2 cancels in WAIT; then timeout racing a cancel.
      rand_op(4'b0100, 1, obs);
      cmp("cancel owner", 32'(obs), 32'h4);
      rand_op(4'b0100, 2, obs);

      // Reset while in ARM, then a clean restart.
      req = 4'b0001; period = {32'd9, 32'd7, 32'd0, 32'd7}; cancel = 4'd0;
      repeat (4) tick();
      chk("arm before reset", 4'h1, 1'b1, A_START, 32'd0, 4'd0, 1'b0);
      #2 reset = 1'b0;
      #1 chk("async reset", 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
      tick();
      chk("held in reset", 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
      #2 reset = 1'b1;
      last_m = 3;
      req = 4'd0;
      rand_op(4'b0001, 0, obs);
      cmp("restart grant", 32'(obs), 32'h1);

      // Fresh reset, then three full rounds with everyone requesting.
      #2 reset = 1'b0;
      #2 reset = 1'b1;
      last_m = 3;
      for (int k = 0; k < 12; k++) begin
         rand_op(4'hF, int'($urandom_range(0, 2)), obs);
         cmp($sformatf("rr order %0d", k), 32'(obs), 32'(1 << (k % 4)));
      end

      for (int k = 0; k < 40; k++) begin
         rand_op(4'd0, -1, obs);
         if ($urandom_range(0, 1) == 1) begin
            req = 4'd0; cancel = 4'($urandom);
            tick();
            chk("idle gap", 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
